// File: rtl/shift_add_mul_ctrl.sv
// Shift-and-add unsigned multiplier sequencer driving one shared strobe/ack adder.
// Define ZERO_SKIP_EN to replace adds of a zero multiplier bit with a 1-cycle SHIFT state.
module shift_add_mul_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_stb,
    output logic               i_ack,
    input  logic [WIDTH-1:0]   i_dat_a,
    input  logic [WIDTH-1:0]   i_dat_b,
    output logic               o_stb,
    output logic [2*WIDTH-1:0] o_dat,
    input  logic               o_ack,
    output logic               add_stb,
    input  logic               add_ack,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    input  logic               add_res_stb,
    input  logic [WIDTH:0]     add_res,
    output logic               add_res_ack
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

`ifdef ZERO_SKIP_EN
    typedef enum logic [2:0] {StIdle, StIssue, StWait, StShift, StDone} state_e;
`else
    typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone} state_e;
`endif

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 o_stb_q, o_stb_d;
    logic [2*WIDTH-1:0]   o_dat_q, o_dat_d;

    // One iteration retires when step is set; step_sum is the new HI plus the bit shifted into LO.
    logic                 step;
    logic [WIDTH:0]       step_sum;
    logic [2*WIDTH-1:0]   shifted;

    assign i_ack       = i_stb & (state_q == StIdle) & ~rst;
    assign add_res_ack = add_res_stb & (state_q == StWait) & ~rst;
    assign add_stb     = (state_q == StIssue);
    assign add_a       = add_stb ? hi_q : '0;
    assign add_b       = (add_stb && lo_q[0]) ? m_q : '0;
    assign o_stb       = o_stb_q;
    assign o_dat       = o_dat_q;

    assign shifted = {step_sum, lo_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        o_stb_d  = o_stb_q;
        o_dat_d  = o_dat_q;
        step     = 1'b0;
        step_sum = '0;

        case (state_q)
            StIdle: begin
                if (i_ack) begin
                    m_d   = i_dat_a;
                    hi_d  = '0;
                    lo_d  = i_dat_b;
                    cnt_d = '0;
`ifdef ZERO_SKIP_EN
                    state_d = i_dat_b[0] ? StIssue : StShift;
`else
                    state_d = StIssue;
`endif
                end
            end
            StIssue: begin
                if (add_ack) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (add_res_ack) begin
                    step     = 1'b1;
                    step_sum = add_res;
                end
            end
`ifdef ZERO_SKIP_EN
            StShift: begin
                step     = 1'b1;
                step_sum = {1'b0, hi_q};
            end
`endif
            StDone: begin
                if (o_ack) begin
                    o_stb_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (step) begin
            {hi_d, lo_d} = shifted;
            cnt_d        = cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) begin
                state_d = StDone;
                o_stb_d = 1'b1;
                o_dat_d = shifted;
            end else begin
`ifdef ZERO_SKIP_EN
                // lo_q[1] becomes LO[0] for the next iteration.
                state_d = lo_q[1] ? StIssue : StShift;
`else
                state_d = StIssue;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            o_stb_q <= 1'b0;
            o_dat_q <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            o_stb_q <= o_stb_d;
            o_dat_q <= o_dat_d;
        end
    end

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Bench for shift_add_mul_ctrl: zero-wait adder model, directed and random products.
module tb_shift_add_mul_ctrl;

`ifdef ZERO_SKIP_EN
    localparam bit Skip = 1'b1;
`else
    localparam bit Skip = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_stb = 1'b0;
    logic        i_ack;
    logic [31:0] i_dat_a = '0;
    logic [31:0] i_dat_b = '0;
    logic        o_stb;
    logic [63:0] o_dat;
    logic        o_ack = 1'b0;
    logic        add_stb;
    logic        add_ack;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_res_stb;
    logic [32:0] add_res;
    logic        add_res_ack;

    // Adder environment: accepts immediately unless stalled, result one cycle later.
    logic        res_valid = 1'b0;
    logic [32:0] res_q = '0;
    logic        add_stall = 1'b0;
    int          stall_left = 0;
    int          proto_err = 0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    shift_add_mul_ctrl #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_stb       (i_stb),
        .i_ack       (i_ack),
        .i_dat_a     (i_dat_a),
        .i_dat_b     (i_dat_b),
        .o_stb       (o_stb),
        .o_dat       (o_dat),
        .o_ack       (o_ack),
        .add_stb     (add_stb),
        .add_ack     (add_ack),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_res_stb (add_res_stb),
        .add_res     (add_res),
        .add_res_ack (add_res_ack)
    );

    assign add_ack     = add_stb & ~res_valid & ~add_stall;
    assign add_res_stb = res_valid;
    assign add_res     = res_q;

    always @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
        end else begin
            if (add_res_stb && !add_res_ack) proto_err <= proto_err + 1;
            if (add_stb && add_ack) begin
                res_q     <= {1'b0, add_a} + {1'b0, add_b};
                res_valid <= 1'b1;
            end else if (res_valid && add_res_ack) begin
                res_valid <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one product from a negedge; returns at a negedge with the DUT back in IDLE.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input int stall, input int hold);
        logic [63:0] exp_p;
        int          exp_lat;
        int          exp_adds;
        int          n;
        int          adds;
        bit          pend;
        logic [31:0] sa;
        logic [31:0] sb;
        exp_p    = {32'b0, a} * {32'b0, b};
        exp_adds = Skip ? $countones(b) : 32;
        exp_lat  = (Skip ? 32 + $countones(b) : 64) + stall;
        adds     = 0;
        pend     = 1'b0;
        sa       = '0;
        sb       = '0;
        stall_left = stall;

        i_stb   = 1'b1;
        i_dat_a = a;
        i_dat_b = b;
        #1 check({tag, ".i_ack"}, {63'b0, i_ack}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        i_stb = 1'b0;
        n = 0;
        while (n <= 300) begin
            if (o_stb) break;
            if (add_stb && stall_left > 0) begin
                add_stall  = 1'b1;
                stall_left = stall_left - 1;
            end else begin
                add_stall = 1'b0;
            end
            if (pend) begin
                check({tag, ".hold_a"}, {32'b0, add_a}, {32'b0, sa});
                check({tag, ".hold_b"}, {32'b0, add_b}, {32'b0, sb});
            end
            pend = add_stb && add_stall;
            sa   = add_a;
            sb   = add_b;
            if (add_stb && !add_stall && !res_valid) adds++;
            @(negedge clk);
            n++;
        end
        add_stall = 1'b0;
        check({tag, ".latency"}, 64'(n), 64'(exp_lat));
        check({tag, ".o_dat"}, o_dat, exp_p);
        check({tag, ".adds"}, 64'(adds), 64'(exp_adds));

        if (hold > 0) begin
            i_stb = 1'b1;
            repeat (hold) begin
                #1;
                check({tag, ".hold_stb"}, {63'b0, o_stb}, 64'd1);
                check({tag, ".hold_dat"}, o_dat, exp_p);
                check({tag, ".busy_i_ack"}, {63'b0, i_ack}, 64'd0);
                @(negedge clk);
            end
            i_stb = 1'b0;
        end
        o_ack = 1'b1;
        @(negedge clk);
        o_ack = 1'b0;
        check({tag, ".o_stb_clr"}, {63'b0, o_stb}, 64'd0);
        check({tag, ".o_dat_kept"}, o_dat, exp_p);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;

        i_stb = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.o_stb", {63'b0, o_stb}, 64'd0);
        check("rst.o_dat", o_dat, 64'd0);
        check("rst.add_stb", {63'b0, add_stb}, 64'd0);
        check("rst.i_ack", {63'b0, i_ack}, 64'd0);
        check("rst.res_ack", {63'b0, add_res_ack}, 64'd0);
        rst   = 1'b0;
        i_stb = 1'b0;
        @(negedge clk);

        run_mul("3x5", 32'd3, 32'd5, 0, 0);
        run_mul("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_mul("bx0", 32'h1234_5678, 32'd0, 0, 0);
        run_mul("7x6", 32'd7, 32'd6, 0, 10);
        run_mul("2x3stall", 32'd2, 32'd3, 3, 0);

        // Abort a product mid-flight with a single reset cycle.
        ra = $urandom;
        rb = $urandom | 32'h1;
        i_stb   = 1'b1;
        i_dat_a = ra;
        i_dat_b = rb;
        @(posedge clk);
        @(negedge clk);
        i_stb = 1'b0;
        repeat (20) @(negedge clk);
        rst   = 1'b1;
        i_stb = 1'b1;
        #1 check("abort.i_ack_rst", {63'b0, i_ack}, 64'd0);
        @(negedge clk);
        check("abort.o_stb", {63'b0, o_stb}, 64'd0);
        check("abort.o_dat", o_dat, 64'd0);
        check("abort.add_stb", {63'b0, add_stb}, 64'd0);
        check("abort.add_a", {32'b0, add_a}, 64'd0);
        check("abort.add_b", {32'b0, add_b}, 64'd0);
        check("abort.i_ack", {63'b0, i_ack}, 64'd0);
        rst   = 1'b0;
        i_stb = 1'b0;
        run_mul("9x9", 32'd9, 32'd9, 0, 0);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_mul("rand", ra, rb, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        check("proto_err", 64'(proto_err), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
